// File: rtl/rom_uart_loader.sv
// Boot loader: receives a framed program image over UART (8N1), writes it into
// the program ROM and releases the CPU core once the checksum verifies.

module rom_uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       line,
    output logic [7:0] rx_byte,
    output logic       rx_vld,
    output logic       frm_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t       state, state_nx;
    logic            sync1, sync2, prev;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            tick;

    always_comb begin
        state_nx = state;
        tick     = 1'b0;
        case (state)
            RX_IDLE:  if (prev && !sync2) state_nx = RX_START;
            RX_START: begin
                tick = (cnt == HALF);
                // a start bit that has gone high again by mid-bit is a glitch
                if (tick) state_nx = sync2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                tick = (cnt == FULL);
                if (tick && bit_idx == 3'd7) state_nx = RX_STOP;
            end
            RX_STOP: begin
                tick = (cnt == FULL);
                if (tick) state_nx = RX_IDLE;
            end
            default: state_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= RX_IDLE;
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            prev    <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            rx_vld  <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            state   <= state_nx;
            sync1   <= line;
            sync2   <= sync1;
            prev    <= sync2;
            rx_vld  <= 1'b0;
            frm_err <= 1'b0;
            cnt     <= (tick || state == RX_IDLE) ? '0 : cnt + 1'b1;
            if (state == RX_DATA && tick) begin
                shreg   <= {sync2, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (state == RX_STOP && tick) begin
                rx_vld  <= sync2;
                frm_err <= !sync2;
            end
        end
    end

    assign rx_byte = shreg;
endmodule

module rom_uart_loader #(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         ADDR_W       = 16,
    parameter int         ROM_DEPTH    = 4096,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              rom_wr_en,
    output logic [ADDR_W-1:0] rom_wr_addr,
    output logic [7:0]        rom_wr_byte,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_err
);
    localparam logic [16:0] DEPTH_MAX = 17'(ROM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_H, S_LEN_L, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  rx_byte;
    logic        rx_vld, frm_err;
    logic [7:0]  len_h;
    logic [15:0] len, cnt, len_full;
    logic [7:0]  csum;
    logic        hdr, last;

    rom_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clock   (clock),
        .reset   (reset),
        .line    (uart_rx),
        .rx_byte (rx_byte),
        .rx_vld  (rx_vld),
        .frm_err (frm_err)
    );

    assign hdr      = rx_vld && (rx_byte == HEADER);
    assign len_full = {len_h, rx_byte};
    assign last     = (cnt + 16'd1) == len;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (hdr) state_nx = S_LEN_H;
            S_LEN_H: if (rx_vld) state_nx = S_LEN_L;
            S_LEN_L: if (rx_vld) begin
                if ({1'b0, len_full} > DEPTH_MAX) state_nx = S_ERR;
                else if (len_full == 16'd0)       state_nx = S_CSUM;
                else                              state_nx = S_DATA;
            end
            S_DATA:  if (rx_vld && last) state_nx = S_CSUM;
            S_CSUM:  if (rx_vld) state_nx = (rx_byte == csum) ? S_DONE : S_ERR;
            default: state_nx = S_IDLE;
        endcase
        if (frm_err && !(state inside {S_IDLE, S_DONE, S_ERR})) state_nx = S_ERR;
    end

    // status drops on the very cycle a new header is accepted
    assign load_done = (state == S_DONE) && !hdr;
    assign load_err  = (state == S_ERR) && !hdr;
    assign core_hold = !load_done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            len_h       <= '0;
            len         <= '0;
            cnt         <= '0;
            csum        <= '0;
            rom_wr_en   <= 1'b0;
            rom_wr_addr <= '0;
            rom_wr_byte <= '0;
        end else begin
            state     <= state_nx;
            rom_wr_en <= 1'b0;
            case (state)
                S_LEN_H: if (rx_vld) len_h <= rx_byte;
                S_LEN_L: if (rx_vld) begin
                    len  <= len_full;
                    cnt  <= '0;
                    csum <= '0;
                end
                S_DATA: if (rx_vld) begin
                    rom_wr_en   <= 1'b1;
                    rom_wr_addr <= ADDR_W'(cnt);
                    rom_wr_byte <= rx_byte;
                    cnt         <= cnt + 16'd1;
                    csum        <= csum + rx_byte;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_uart_loader.sv
// Scoreboard bench for rom_uart_loader: frames are built at byte level, expected
// ROM writes are queued and a monitor checks every write strobe.

module tb_rom_uart_loader;
    localparam int CPB   = 16;
    localparam int DEPTH = 4096;

    typedef logic [7:0] byte_q_t[$];

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        uart_rx = 1'b1;
    logic        rom_wr_en;
    logic [15:0] rom_wr_addr;
    logic [7:0]  rom_wr_byte;
    logic        core_hold, load_done, load_err;

    int vectors = 0;
    int miscompares = 0;
    logic [23:0] exp_q[$];

    always #5 clock = ~clock;

    rom_uart_loader #(
        .CLKS_PER_BIT(CPB), .ADDR_W(16), .ROM_DEPTH(DEPTH), .HEADER(8'hA5)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .uart_rx     (uart_rx),
        .rom_wr_en   (rom_wr_en),
        .rom_wr_addr (rom_wr_addr),
        .rom_wr_byte (rom_wr_byte),
        .core_hold   (core_hold),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Write monitor: every strobe must match the head of the expected queue.
    always @(negedge clock) begin
        if (reset && rom_wr_en) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                         rom_wr_addr, rom_wr_byte);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                check("wr_addr", rom_wr_addr, e[23:8]);
                check("wr_byte", rom_wr_byte, e[7:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        @(negedge clock);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clock);
        uart_rx = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    function automatic logic [7:0] sum8(input byte_q_t d);
        int s = 0;
        foreach (d[i]) s += int'(d[i]);
        return 8'(s % 256);
    endfunction

    task automatic check_status(input string tag, input logic done, input logic err);
        repeat (4) @(negedge clock);
        check({tag, ".load_done"}, load_done, done);
        check({tag, ".load_err"}, load_err, err);
        check({tag, ".core_hold"}, core_hold, !done);
        check({tag, ".pending_writes"}, exp_q.size(), 0);
    endtask

    // Sends a full frame; returns the reference verdict (1 = image accepted).
    task automatic send_frame(input string tag, input byte_q_t data, input logic [15:0] len,
                              input logic [7:0] csum, output logic ok);
        send_byte(8'hA5);
        check({tag, ".hdr_hold"}, core_hold, 1);
        check({tag, ".hdr_done"}, load_done, 0);
        check({tag, ".hdr_err"}, load_err, 0);
        send_byte(len[15:8]);
        send_byte(len[7:0]);
        foreach (data[i]) begin
            exp_q.push_back({16'(i), data[i]});
            send_byte(data[i]);
        end
        send_byte(csum);
        ok = (int'(len) <= DEPTH) && (csum == sum8(data));
    endtask

    initial begin
        byte_q_t d;
        logic ok;

        #1;
        check("rst.wr_en", rom_wr_en, 0);
        check("rst.hold", core_hold, 1);
        check("rst.done", load_done, 0);
        check("rst.err", load_err, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // glitch in idle, then a frame that would be misaligned if it were taken as a start
        uart_rx = 1'b0;
        @(negedge clock);
        uart_rx = 1'b1;
        repeat (20) @(negedge clock);
        d = '{8'h12, 8'h34, 8'h56};
        send_frame("t1", d, 16'd3, 8'h9C, ok);
        check("t1.model_ok", ok, 1);
        check_status("t1", 1, 0);

        d = '{8'hAA, 8'h55};
        send_frame("t2", d, 16'd2, 8'h00, ok);
        check_status("t2", ok, !ok);
        d = '{8'h12, 8'h34, 8'h56};
        send_frame("t2b", d, 16'd3, 8'h9C, ok);
        check_status("t2b", ok, !ok);

        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
        d = '{8'h7E};
        send_frame("t3", d, 16'd1, 8'h7E, ok);
        check_status("t3", ok, !ok);

        // oversize length: error right after LEN_L, following bytes ignored
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h01);
        check_status("t4", 0, 1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        check_status("t4b", 0, 1);

        // framing error mid-frame
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        exp_q.push_back({16'd0, 8'h11});
        send_byte(8'h11);
        send_byte(8'h22, 1'b0);
        check_status("t5", 0, 1);

        // reset mid-frame, checked asynchronously away from any clock edge
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04);
        exp_q.push_back({16'd0, 8'hC1});
        send_byte(8'hC1);
        exp_q.push_back({16'd1, 8'hC2});
        send_byte(8'hC2);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("t6.wr_en", rom_wr_en, 0);
        check("t6.hold", core_hold, 1);
        check("t6.done", load_done, 0);
        check("t6.err", load_err, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        d = {};
        send_frame("t6b", d, 16'd0, 8'h00, ok);
        check_status("t6b", ok, !ok);

        // randomized frames with optional junk lead-in and corrupted checksums
        for (int n = 0; n < 8; n++) begin
            int len;
            int junk;
            logic [7:0] cs;
            len  = $urandom_range(0, 16);
            junk = $urandom_range(0, 2);
            for (int j = 0; j < junk; j++) begin
                logic [7:0] jb;
                jb = 8'($urandom_range(0, 255));
                if (jb == 8'hA5) jb = 8'h5A;
                send_byte(jb);
            end
            d = {};
            for (int i = 0; i < len; i++) d.push_back(8'($urandom_range(0, 255)));
            cs = sum8(d);
            if ($urandom_range(0, 1) == 1) cs = cs + 8'($urandom_range(1, 255));
            send_frame($sformatf("rnd%0d", n), d, 16'(len), cs, ok);
            check_status($sformatf("rnd%0d", n), ok, !ok);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rom_uart_loader.md
Name: rom_uart_loader

Overview:
- Boot-time program loader that sits directly upstream of the program ROM.
- Receives a framed program image over a UART RX line and writes it byte-by-byte into the ROM write port.
- Holds the CPU core (control unit and datapath) in reset until a complete, checksum-valid image has been written.
- Lets the 8051 core run code downloaded at power-up instead of a synthesis-time image.

Parameters:
CLKS_PER_BIT, 868, system clocks per UART bit (100 MHz / 115200); minimum 8
ADDR_W, 16, ROM address width (matches rom_addr)
ROM_DEPTH, 4096, maximum image length in bytes; larger lengths are rejected
HEADER, 8'hA5, frame start byte

Ports:
clock        in   1       system clock, rising edge
reset        in   1       asynchronous, active-low reset
uart_rx      in   1       serial input, idle high, 8N1, LSB first
rom_wr_en    out  1       one-cycle ROM write strobe
rom_wr_addr  out  ADDR_W  ROM write address
rom_wr_byte  out  8       ROM write data
core_hold    out  1       1 = hold CPU core in reset
load_done    out  1       level; image loaded and verified
load_err     out  1       level; last frame failed

Behaviour:
Reset (reset=0, asynchronous):
- All outputs 0 except core_hold=1.
- FSM goes to IDLE; counters, checksum and address are cleared.

UART receiver:
- uart_rx passes through a 2-flop synchronizer.
- Start is detected on a falling edge while the receiver is idle. The start bit is re-sampled at CLKS_PER_BIT/2; if it reads 1, treat it as a glitch and return to idle.
- Data bits are sampled every CLKS_PER_BIT thereafter, LSB first. The stop bit is sampled once.
- rx_vld (internal) pulses for one cycle after the stop-bit sample, with rx_byte valid.
- Stop bit = 0 → internal framing error pulse; no rx_vld.
- The receiver returns to idle immediately after the stop sample and can accept back-to-back bytes.

Frame format: HEADER, LEN_H, LEN_L, LEN data bytes, CSUM.
- CSUM = 8-bit modulo-256 sum of the data bytes only.

FSM states: IDLE, LEN_H, LEN_L, DATA, CSUM, DONE, ERR.
- IDLE: rx_vld with byte==HEADER → LEN_H. Any other byte is ignored.
- LEN_H: capture length[15:8] → LEN_L.
- LEN_L: capture length[7:0], then:
  - length > ROM_DEPTH → ERR.
  - length == 0 → CSUM.
  - otherwise → DATA.
  - In all cases, clear the address counter and checksum.
- DATA: each rx_vld does the following:
  - Next cycle: rom_wr_en=1, rom_wr_byte=byte, rom_wr_addr=address counter.
  - Address counter increments and checksum accumulates (8-bit wrap).
  - After the LEN-th byte → CSUM.
  - Write latency is exactly 1 clock after rx_vld.
- CSUM: received byte == checksum → DONE; otherwise → ERR.
- DONE: load_done=1, core_hold=0, load_err=0.
- ERR: load_err=1, load_done=0, core_hold=1.
- From DONE or ERR, a HEADER byte starts a new frame (→ LEN_H):
  - core_hold=1 and load_done=0 on the cycle the header is accepted.
  - load_err clears on the same cycle.
- Framing error in any state other than IDLE/DONE/ERR → ERR. In IDLE, DONE or ERR a framing error is ignored.
- rom_wr_addr holds its last value between strobes. rom_wr_en is never asserted outside DATA.
- Address never wraps: length ≤ ROM_DEPTH guarantees addresses 0..LEN-1.
- No inter-byte timeout; a stalled frame waits indefinitely (only reset or a framing error recovers).
- Reset mid-frame: immediate return to reset values. Partially written ROM contents are left as-is, and core_hold stays 1.

Test Plan:
All tests use CLKS_PER_BIT=16.
1. Stream A5 00 03 12 34 56 9C → three rom_wr_en pulses with addr/data 0/12, 1/34, 2/56, each 1 clock after the byte's stop sample; then load_done=1, core_hold=0, load_err=0.
2. Stream A5 00 02 AA 55 00 (correct CSUM is FF) → two writes occur; load_err=1, core_hold=1, load_done=0. Then send the scenario-1 frame → load_done=1, load_err=0.
3. Send bytes 00 FF 3C before A5 00 01 7E 7E → leading bytes produce no writes; exactly one write, addr 0 data 7E; load_done=1.
4. A5 10 01 (length 4097 > ROM_DEPTH) → load_err=1 immediately after LEN_L; no rom_wr_en pulses; subsequent data bytes are ignored until the next A5.
5. A5 00 02 11, then a byte with stop bit forced 0 → load_err=1 and exactly one write (addr 0, data 11). A 1-clock low glitch on uart_rx in IDLE → no byte received.
6. Assert reset low for 3 cycles after the second data byte of a 4-byte frame → outputs go to reset values asynchronously (core_hold=1, rom_wr_en=0). Then stream A5 00 00 00 → load_done=1 with zero writes.
